data_memory_ctrl: RTL
=====================

// Module: data_memory_ctrl
// PURPOSE
// - Parametrised data-memory controller for the RV32I core's MEM stage: RAM plus MMIO (LED register, halt register).
// - Serves one load/store at a time over a valid/ready request and response handshake.
// - Read latency is configurable. Reads are registered, not combinational.
// - Flags misaligned, illegal-funct3 and unmapped accesses with a fault bit instead of silently aliasing.
// - Replaces the simulation-only $finish halt with a sticky halt output.
// PARAMETERS
// DEPTH_WORDS     1024           RAM depth in 32-bit words; power of two, >= 2
// RAM_BASE        32'h0000_0000  byte address of RAM word 0; aligned to DEPTH_WORDS*4
// LED_WIDTH       4              width of the LED MMIO register, 1..32
// WAIT_STATES     0              extra cycles inserted before each response, 0..15
// MMIO_LED_ADDR   32'h8000_0000  store sets LEDs; load returns them zero-extended
// MMIO_HALT_ADDR  32'h8000_0004  word store raises halt
// INIT_FILE       ""             if non-empty, RAM is loaded with $readmemh at time 0
// PORTS
// clk          in   1          rising-edge clock
// rst          in   1          synchronous reset, active-high
// req_valid    in   1          request present
// req_ready    out  1          controller can accept a request
// req_we       in   1          1 = store, 0 = load
// req_funct3   in   3          RV32I load/store funct3 (riscv_pkg F3_* constants)
// req_addr     in   32         byte address
// req_wdata    in   32         store data, right-aligned
// resp_valid   out  1          response present
// resp_ready   in   1          consumer accepts the response
// resp_rdata   out  32         load result, sign- or zero-extended; 0 for stores and faults
// resp_fault   out  1          access faulted; no state was changed
// leds_out     out  LED_WIDTH  LED register
// halt         out  1          sticky; set by a store to MMIO_HALT_ADDR
// halt_code    out  32         store data captured with halt
// BEHAVIOUR
// - Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, leds_out=0, halt=0, halt_code=0, FSM=IDLE.
// - RAM contents are not reset.
// - FSM states: IDLE -> (WAIT if WAIT_STATES>0) -> RESP -> IDLE.
//   - req_ready = (state==IDLE) && !halt.
//   - Accept = req_valid && req_ready. On accept, latch the request and go to WAIT (counter = WAIT_STATES) or straight to RESP.
//   - WAIT decrements the counter each cycle and moves to RESP when it reaches 1.
//   - RESP holds resp_valid and the payload stable until resp_ready=1, then returns to IDLE.
// - Latency: resp_valid rises exactly 1+WAIT_STATES cycles after the accept edge.
// - Throughput: at most one access per 2+WAIT_STATES cycles; there are no back-to-back accepts.
// - Loads: the RAM word is read synchronously at the accept edge, then lane-extracted.
//   - lb/lbu select byte addr[1:0]; lh/lhu select half addr[1]; lb/lh sign-extend; lbu/lhu zero-extend.
// - Stores: commit at the accept edge using byte strobes.
//   - sb writes lane addr[1:0]; sh writes lanes {addr[1],0..1}; sw writes all 4 lanes.
//   - Unwritten bytes are preserved (no read-modify-write hazard).
// - Fault conditions: any of the following sets resp_fault=1, forces resp_rdata=0, and suppresses all writes (RAM, LEDs, halt).
//   - Misaligned access: half-word with addr[0]=1, or word with addr[1:0]!=0.
//   - Illegal funct3: loads other than 000/001/010/100/101; stores other than 000/001/010.
//   - Unmapped address: outside [RAM_BASE, RAM_BASE+DEPTH_WORDS*4) and not an MMIO address.
// - MMIO, LED register:
//   - Any legal store width to MMIO_LED_ADDR sets leds_out = wdata[LED_WIDTH-1:0]; visible the cycle after accept.
//   - A word load returns it zero-extended. Sub-word MMIO access faults.
// - MMIO, halt register:
//   - Only an sw is legal.
//   - sw sets halt=1 and halt_code=wdata, and still produces a normal response.
//   - halt then holds req_ready=0 until rst.
//   - A load returns 0.
// - Reset mid-operation: rst in WAIT or RESP drops the pending response (resp_valid stays 0). A store already committed at accept remains.
// - rst with req_valid=1: no accept occurs in that cycle.
// STRUCTURE
// - riscv_pkg gains:
//   - F3_WORD (3'b010), used alongside the existing F3_BYTE/F3_HALF/F3_BU/F3_HU.
//   - typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_RESP} dmem_state_t.
//   - Default MMIO address localparams.
// - One sub-module, lsu_align (purely combinational): from funct3, addr[1:0] and wdata, produce the 4-bit byte strobe,
//   the lane-shifted store data, the misalign/illegal flags, and the load extract/extend of a 32-bit word.
// - The controller owns the FSM, wait counter, RAM array, address decode and MMIO registers.
// TESTING
// 1. sw 0x11223344 @0x100; sb 0xAB @0x101; lw @0x100 -> 0x1122AB44; lb @0x101 -> 0xFFFFFFAB; lbu @0x101 -> 0x000000AB.
// 2. sh 0xBEEF @0x102 -> lh @0x102 = 0xFFFFBEEF, lhu @0x102 = 0x0000BEEF, lw @0x100 = 0xBEEFAB44.
// 3. lw @0x102 -> fault=1, rdata=0; sw 0xDEADBEEF @0x101 -> fault=1, then lw @0x100 still 0xBEEFAB44; funct3=3'b011 load -> fault.
// 4. WAIT_STATES=3: resp_valid rises exactly 4 cycles after accept; resp_ready low 5 cycles -> payload stable, req_ready=0 throughout.
// 5. sw 0x5 @0x8000_0000 -> leds_out=4'h5 next cycle; sw 0x1 @0x8000_0004 -> halt=1, halt_code=1, req_ready stays 0 until rst.
// 6. lw @RAM_BASE+DEPTH_WORDS*4 -> fault=1; assert rst during WAIT -> no resp_valid, req_ready=1 the cycle after rst falls.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings and data-memory controller types.
package riscv_pkg;

    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_HALF = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_WAIT,
        DM_RESP
    } dmem_state_t;

    localparam logic [31:0] MMIO_LED_ADDR_DEFAULT  = 32'h8000_0000;
    localparam logic [31:0] MMIO_HALT_ADDR_DEFAULT = 32'h8000_0004;

endpackage

// File: rtl/data_memory_ctrl_lsu_align.sv
// Byte-lane alignment for loads and stores: strobes, store lane data, access checks
// and load extraction/extension. Purely combinational.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata_lane,
    output logic        misalign,
    output logic        illegal,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store data is replicated across lanes; the strobe picks the lane that lands.
    always_comb begin
        strb       = 4'b0000;
        wdata_lane = 32'h0;
        misalign   = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_BYTE: begin
                strb       = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            F3_HALF: begin
                misalign   = addr_lo[0];
                strb       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            F3_WORD: begin
                misalign   = |addr_lo;
                strb       = 4'b1111;
                wdata_lane = wdata;
            end
            F3_BU: begin
                illegal = we;
            end
            F3_HU: begin
                illegal  = we;
                misalign = addr_lo[0];
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (!we) begin
            strb = 4'b0000;
        end
    end

    always_comb begin
        ld_byte = 8'h0;
        case (ld_addr_lo)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_BYTE: ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_HALF: ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-outstanding data-memory controller: RAM plus LED/halt MMIO behind
// valid/ready request and response handshakes, with configurable wait states.
//
// state   | meaning
// DM_IDLE | ready for a request (unless halted)
// DM_WAIT | counting down wait states before the response
// DM_RESP | response held until the consumer takes it
module data_memory_ctrl
    import riscv_pkg::*;
#(
    parameter int          DEPTH_WORDS    = 1024,
    parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
    parameter int          LED_WIDTH      = 4,
    parameter int          WAIT_STATES    = 0,
    parameter logic [31:0] MMIO_LED_ADDR  = MMIO_LED_ADDR_DEFAULT,
    parameter logic [31:0] MMIO_HALT_ADDR = MMIO_HALT_ADDR_DEFAULT,
    parameter string       INIT_FILE      = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 resp_fault,
    output logic [LED_WIDTH-1:0] leds_out,
    output logic                 halt,
    output logic [31:0]          halt_code
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    dmem_state_t state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;

    logic        we_q, fault_q, is_ram_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [31:0] mmio_word_q;
    logic [31:0] ram_q;
    logic [LED_WIDTH-1:0] leds_q;
    logic        halt_q;
    logic [31:0] halt_code_q;

    logic [31:0] ram [DEPTH_WORDS];

    logic [31:0] ram_off;
    logic [AW-1:0] ram_idx;
    logic        in_ram, is_led, is_halt, ram_hit, mmio_bad;
    logic        misalign, illegal, req_fault;
    logic        accept, commit, ram_wr;
    logic [3:0]  strb;
    logic [31:0] wdata_lane, ld_data;

    lsu_align u_align (
        .we         (req_we),
        .funct3     (req_funct3),
        .addr_lo    (req_addr[1:0]),
        .wdata      (req_wdata),
        .strb       (strb),
        .wdata_lane (wdata_lane),
        .misalign   (misalign),
        .illegal    (illegal),
        .ld_funct3  (f3_q),
        .ld_addr_lo (lane_q),
        .ld_word    (is_ram_q ? ram_q : mmio_word_q),
        .ld_data    (ld_data)
    );

    // MMIO decode wins if a register address ever falls inside the RAM window.
    always_comb begin
        ram_off   = req_addr - RAM_BASE;
        ram_idx   = ram_off[AW+1:2];
        in_ram    = {1'b0, ram_off} < RAM_BYTES;
        is_led    = req_addr == MMIO_LED_ADDR;
        is_halt   = req_addr == MMIO_HALT_ADDR;
        ram_hit   = in_ram && !is_led && !is_halt;
        mmio_bad  = (is_led && !req_we && req_funct3 != F3_WORD) ||
                    (is_halt && req_funct3 != F3_WORD);
        req_fault = misalign || illegal || mmio_bad || !(in_ram || is_led || is_halt);
        req_ready = (state_q == DM_IDLE) && !halt_q;
        accept    = req_valid && req_ready && !rst;
        commit    = accept && !req_fault;
        ram_wr    = commit && req_we && ram_hit;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ram_q <= ram[ram_idx];
        end
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) begin
                    ram[ram_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            DM_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_d    = DM_WAIT;
                        wait_cnt_d = 4'(WAIT_STATES);
                    end else begin
                        state_d = DM_RESP;
                    end
                end
            end
            DM_WAIT: begin
                if (wait_cnt_q <= 4'd1) begin
                    state_d = DM_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            DM_RESP: begin
                if (resp_ready) begin
                    state_d = DM_IDLE;
                end
            end
            default: state_d = DM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DM_IDLE;
            wait_cnt_q  <= 4'd0;
            we_q        <= 1'b0;
            fault_q     <= 1'b0;
            is_ram_q    <= 1'b0;
            f3_q        <= F3_WORD;
            lane_q      <= 2'd0;
            mmio_word_q <= 32'h0;
            leds_q      <= '0;
            halt_q      <= 1'b0;
            halt_code_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (accept) begin
                we_q        <= req_we;
                fault_q     <= req_fault;
                is_ram_q    <= ram_hit;
                f3_q        <= req_funct3;
                lane_q      <= req_addr[1:0];
                mmio_word_q <= is_led ? 32'(leds_q) : 32'h0;
            end
            if (commit && req_we && is_led) begin
                leds_q <= req_wdata[LED_WIDTH-1:0];
            end
            if (commit && req_we && is_halt) begin
                halt_q      <= 1'b1;
                halt_code_q <= req_wdata;
            end
        end
    end

    always_comb begin
        resp_valid = state_q == DM_RESP;
        resp_fault = resp_valid && fault_q;
        resp_rdata = (resp_valid && !fault_q && !we_q) ? ld_data : 32'h0;
        leds_out   = leds_q;
        halt       = halt_q;
        halt_code  = halt_code_q;
    end

endmodule
